// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchronizer plus stability-counter debouncer
// Optional rise/fall edge pulse registers are enabled by SYNC_DEBOUNCE_EDGE_EN.
module sync_debounce #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             q_q;
    logic             q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;

    // Any return of s2 to q, or a completed qualification, clears the counter.
    always_comb begin
        q_d   = q_q;
        cnt_d = '0;
        if (s2_q != q_q) begin
            if (cnt_q == CNT_MAX) begin
                q_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            q_q    <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign q    = q_q;
    assign busy = busy_q;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Pulses are computed from the next q so they line up with the q update.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - directed self-checking bench for sync_debounce
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic din = 1'b0;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int checks = 0;
    int errors = 0;

    sync_debounce #(.STABLE_CYCLES(4)) dut (
        .clk  (clk),
        .clr  (clr),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #50 clk = ~clk;

    task automatic test_reset;
        logic [3:0] exp;
        clr = 1'b0;
        din = 1'b0;
        #10;
        checks++;
        if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got %b want 0000", {q, rise, fall, busy});
        end
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp = 4'b0000;
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL reset_idle edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_rise;
        logic [3:0] exp;
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp = {e >= 6, EDGE_EN && e == 6, 1'b0, e >= 3 && e <= 5};
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL rise edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_fall;
        logic [3:0] exp;
        din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp = {e < 6, 1'b0, EDGE_EN && e == 6, e >= 3 && e <= 5};
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL fall edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_glitch;
        logic [3:0] exp;
        din = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e == 2) din = 1'b0;
            exp = {1'b0, 1'b0, 1'b0, e == 3 || e == 4};
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL glitch edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp;
        din = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            exp = {1'b0, 1'b0, 1'b0, e >= 3};
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL midrst_pre edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
        #20 clr = 1'b0;
        #1;
        checks++;
        if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async got %b want 0000", {q, rise, fall, busy});
        end
        @(posedge clk); #1;
        checks++;
        if ({q, rise, fall, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_hold got %b want 0000", {q, rise, fall, busy});
        end
        #30 clr = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            exp = {e >= 6, EDGE_EN && e == 6, 1'b0, e >= 3 && e <= 5};
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL midrst_post edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp;
        din = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (e == 6) din = 1'b1;
            exp = {e < 6 || e >= 12, EDGE_EN && e == 12, EDGE_EN && e == 6,
                   (e >= 3 && e <= 5) || (e >= 9 && e <= 11)};
            checks++;
            if ({q, rise, fall, busy} !== exp) begin
                errors++;
                $display("FAIL b2b edge %0d got %b want %b", e, {q, rise, fall, busy}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive clocks the synchronized input must differ from the output before the output follows; legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(STABLE_CYCLES), is the stability counter width; it is derived, not overridden.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 clr  input  1  is the reset: asynchronous, active-low.
REQ-005 din  input  1  is the raw, asynchronous level (switch/button); it may change at any time.
REQ-006 q  output  1  is the debounced, synchronous level; it is the data source for the downstream clearable D flip-flop stage.
REQ-007 rise  output  1  is a one-clock pulse on a q 0->1 transition.
REQ-008 fall  output  1  is a one-clock pulse on a q 1->0 transition.
REQ-009 busy  output  1  is high while the stability counter is nonzero (a candidate change is pending).

Function
REQ-010 din shall pass through a two-flop synchronizer (s1, s2); s2 equals din as sampled two rising edges earlier.
REQ-011 On each rising edge where s2 == q: counter cleared to 0; q unchanged.
REQ-012 On each rising edge where s2 != q and counter < STABLE_CYCLES-1: counter increments by 1.
REQ-013 On each rising edge where s2 != q and counter == STABLE_CYCLES-1: q <= s2; counter cleared to 0.
REQ-014 Latency: a clean din step applied before edge 1 changes q at rising edge 2+STABLE_CYCLES (edge 6 at default); there is no combinational path from din to any output.
REQ-015 Glitch rejection: if s2 returns to q before the counter reaches STABLE_CYCLES-1, the counter clears, q does not change, and no pulse is issued.
REQ-016 rise and fall are registered and assert in the same cycle q changes, for exactly one cycle; they are never high simultaneously.
REQ-017 busy is a registered output equal to (counter != 0).
REQ-018 The counter never exceeds STABLE_CYCLES-1 and never wraps.
REQ-019 Back-to-back changes: after q updates, the opposite transition requires a fresh full STABLE_CYCLES qualification; the minimum q pulse width is STABLE_CYCLES clocks.

Reset
REQ-020 While clr is low: s1, s2, q, rise, fall, busy = 0 and counter = 0, immediately, independent of clk.
REQ-021 Reset asserted mid-qualification discards the pending change; no rise or fall pulse is emitted on reset entry or exit.
REQ-022 After clr deasserts, with din held 1, q rises at the 2+STABLE_CYCLES edge after the first edge following deassertion, with a rise pulse.

Configuration
REQ-023 Macro SYNC_DEBOUNCE_EDGE_EN: when defined, rise and fall are generated per REQ-007, REQ-008 and REQ-016.
REQ-024 When SYNC_DEBOUNCE_EDGE_EN is undefined, rise and fall remain ports but are tied to constant 0 with no edge registers; q and busy behaviour is identical.

Verification
REQ-025 STABLE_CYCLES=4, clk period 100 ns, clr low then high, din=0 held -> q=0, busy=0, rise=fall=0 throughout.
REQ-026 din 0->1 before edge 1, held -> busy high at edges 3-5, q=1 and rise=1 at edge 6 only, busy=0 after edge 6.
REQ-027 din high for 2 clocks, then low -> busy pulses, counter clears, q stays 0, rise never asserts.
REQ-028 q=1 settled, din 1->0 held -> q=0 and fall=1 at edge 6, one cycle.
REQ-029 din 0->1, clr pulsed low between edges 4 and 5 -> all outputs 0 immediately, no pulse, and q=1 only 6 edges after clr release.
REQ-030 Build without SYNC_DEBOUNCE_EDGE_EN, repeat REQ-026 and REQ-028 -> q timing identical, rise and fall constant 0.
